commit_trace_tx: RTL
====================

Name: commit_trace_tx

Overview:
- Synthesizable transmitter for per-instruction commit trace. Sits beside the core and samples one commit record per retired instruction: PC, instruction, register write, memory write.
- Buffers records in a small FIFO and serializes each into a variable-length byte frame on a valid/ready byte channel (UART bridge or debug DMA).
- A host-side decoder rebuilds the textual cycle log from these frames.

Parameters:
- DEPTH, 4, FIFO depth in records; power of two, minimum 2.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  32  PC of the retiring instruction
- commit_instr  in  32  instruction word
- commit_reg_write  in  1  register file write enable
- commit_rd  in  5  destination register
- commit_rd_wdata  in  32  value written to rd
- commit_mem_we  in  1  memory write enable
- commit_mem_addr  in  32  memory write address
- commit_mem_wdata  in  32  memory write data
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts the byte
- busy  out  1  FIFO non-empty or frame in progress
- drop_cnt  out  8  saturating count of dropped records

Behaviour:
- Reset (async assert, sync release): tx_valid=0, tx_data=0, busy=0, drop_cnt=0. FIFO emptied, seq=0, drop_pending=0, FSM=IDLE. Reset mid-frame aborts the frame; no partial resume.
- Flag W = commit_reg_write && commit_rd!=0. Flag M = commit_mem_we.
- Enqueue on each edge where commit_valid=1 and the FIFO is not full. The record stores the inputs, W, M, the current seq and drop_pending; drop_pending then clears.
- Full is evaluated before any same-cycle pop. A commit arriving while full is dropped: drop_pending=1, drop_cnt+=1 (saturates at 255).
- seq is 8 bits and increments on every commit_valid, enqueued or dropped. It wraps 255->0, so gaps are visible to the host.
- Frame bytes, multi-byte fields little-endian:
  - 0xA5
  - flags = {5'b0, D, M, W}
  - seq
  - pc[4]
  - instr[4]
  - if W: {3'b0, rd}, rd_wdata[4]
  - if M: mem_addr[4], mem_wdata[4]
- Frame length: 11 bytes base, +5 if W, +8 if M; maximum 24.
- FSM:
  - IDLE: when the FIFO is non-empty, load the head, drive byte 0, go to SEND.
  - SEND: a byte completes when tx_valid && tx_ready. byte_idx (5 bits) advances; skipped sections are not emitted.
  - On acceptance of the last byte, pop the head. If the FIFO is still non-empty, byte 0 of the next frame is driven on the following cycle with no bubble; otherwise go to IDLE with tx_valid=0.
- tx_valid and tx_data are registered. While tx_valid && !tx_ready, tx_data holds stable and tx_valid stays high.
- Latency: a commit sampled at edge E into an empty, IDLE block gives tx_valid=1 after edge E+1.
- Simultaneous enqueue and pop in one cycle are both honoured; occupancy is unchanged.
- busy = FIFO non-empty || FSM==SEND, registered.

Optional Feature:
- Macro: COMMIT_TRACE_CHECKSUM_EN.
- Defined: every frame gets one trailing byte equal to the XOR of all preceding frame bytes, 0xA5 included. Frame lengths become 12/17/20/25, and the frame ends when the checksum byte is accepted.
- Undefined: no checksum byte; lengths as listed under Behaviour.

Test Plan:
- Single commit, pc=0x00000010, instr=0x00500093, reg_write=1, rd=1, wdata=5, tx_ready=1 -> tx_valid rises after edge E+1. Bytes: A5 01 00 10 00 00 00 93 00 50 00 01 05 00 00 00. tx_valid then falls.
- Store commit, pc=0x20, instr=0x00112023, mem_we=1, addr=0x100, data=0xDEADBEEF, reg_write=0 -> 19 bytes. flags=0x02. Tail: 00 01 00 00 EF BE AD DE.
- Backpressure: toggle tx_ready 1,0,0,1 mid-frame -> tx_data stable while stalled, no byte lost or repeated, frame content matches the tx_ready=1 case.
- Overflow with DEPTH=4 and tx_ready=0: 6 consecutive commits -> drop_cnt=2, records seq 0..3 queued. Release tx_ready and issue one more commit -> it is emitted with seq=6 and flags bit2=1.
- Back-to-back: 3 commits at tx_ready=1 -> frames contiguous with no idle cycle between them, seq 0,1,2, busy falls one cycle after the last byte.
- reset_n pulsed low at byte 7 of a frame -> tx_valid=0 immediately. After release, the next commit produces a frame with seq=0 and drop_cnt=0.

Source files
------------

// File: rtl/commit_trace_tx.sv
// rtl/commit_trace_tx.sv - commit trace record FIFO and byte-frame serializer (optional COMMIT_TRACE_CHECKSUM_EN)
module commit_trace_tx #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_instr,
  input  logic        commit_reg_write,
  input  logic [4:0]  commit_rd,
  input  logic [31:0] commit_rd_wdata,
  input  logic        commit_mem_we,
  input  logic [31:0] commit_mem_addr,
  input  logic [31:0] commit_mem_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Byte positions in the full frame layout; sections absent from a record are skipped.
  localparam logic [4:0] POS_RD   = 5'd11;
  localparam logic [4:0] POS_MEM  = 5'd16;
  localparam logic [4:0] POS_TAIL = 5'd24;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  seq;
    logic        d;
    logic        m;
    logic        w;
  } rec_t;

  typedef enum logic {IDLE, SEND} state_t;

  rec_t          mem [DEPTH];
  rec_t          head;
  rec_t          wr_rec;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [7:0]    seq;
  logic          drop_pending;
  state_t        state;
  logic [4:0]    byte_idx;
  logic [4:0]    idx_nxt;
  logic [7:0]    byte_nxt;
  logic [7:0]    csum;
  logic          full;
  logic          push;
  logic          pop;
  logic          is_last;

  // Byte at a given layout position; multi-byte fields are little-endian.
  function automatic logic [7:0] frame_byte(input rec_t r, input logic [4:0] idx);
    logic [1:0] lo;
    logic [7:0] b;
    // pc starts at 3 and instr at 7, both congruent to 3 mod 4
    lo = idx[1:0] + 2'd1;
    b  = 8'h00;
    case (idx)
      5'd0:                       b = 8'hA5;
      5'd1:                       b = {5'b0, r.d, r.m, r.w};
      5'd2:                       b = r.seq;
      5'd3,  5'd4,  5'd5,  5'd6:  b = r.pc[{lo, 3'b000} +: 8];
      5'd7,  5'd8,  5'd9,  5'd10: b = r.instr[{lo, 3'b000} +: 8];
      5'd11:                      b = {3'b000, r.rd};
      5'd12, 5'd13, 5'd14, 5'd15: b = r.rd_wdata[{idx[1:0], 3'b000} +: 8];
      5'd16, 5'd17, 5'd18, 5'd19: b = r.mem_addr[{idx[1:0], 3'b000} +: 8];
      5'd20, 5'd21, 5'd22, 5'd23: b = r.mem_wdata[{idx[1:0], 3'b000} +: 8];
      default:                    b = 8'h00;
    endcase
    return b;
  endfunction

  // Next emitted position, jumping over the register and memory sections when absent.
  function automatic logic [4:0] next_index(input rec_t r, input logic [4:0] idx);
    logic [4:0] n;
    n = idx + 5'd1;
    if (n == POS_RD && !r.w) n = POS_MEM;
    if (n == POS_MEM && !r.m) n = POS_TAIL;
    return n;
  endfunction

  assign head      = mem[rd_ptr];
  assign full      = (count == FULL_COUNT);
  assign push      = commit_valid && !full;
  assign idx_nxt   = next_index(head, byte_idx);
  assign byte_nxt  = (idx_nxt == POS_TAIL) ? csum : frame_byte(head, idx_nxt);
  assign pop       = (state == SEND) && tx_valid && tx_ready && is_last;
  assign count_nxt = count + (AW + 1)'(push) - (AW + 1)'(pop);

`ifdef COMMIT_TRACE_CHECKSUM_EN
  assign is_last = (byte_idx == POS_TAIL);
`else
  assign is_last = (idx_nxt == POS_TAIL);
`endif

  // Snapshot of the retiring instruction with its flags, sequence and drop marker.
  always_comb begin
    wr_rec           = '0;
    wr_rec.pc        = commit_pc;
    wr_rec.instr     = commit_instr;
    wr_rec.rd        = commit_rd;
    wr_rec.rd_wdata  = commit_rd_wdata;
    wr_rec.mem_addr  = commit_mem_addr;
    wr_rec.mem_wdata = commit_mem_wdata;
    wr_rec.seq       = seq;
    wr_rec.d         = drop_pending;
    wr_rec.m         = commit_mem_we;
    wr_rec.w         = commit_reg_write && (commit_rd != 5'd0);
  end

  // Record storage; entries are only read while counted, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  // FIFO pointers, sequence numbering and drop bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      seq          <= 8'd0;
      drop_pending <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (commit_valid) seq <= seq + 8'd1;
      if (commit_valid && full) begin
        drop_pending <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (push) begin
        drop_pending <= 1'b0;
      end
    end
  end

  // Frame serializer: registered byte stream, next frame starts without a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      byte_idx <= 5'd0;
      csum     <= 8'h00;
      busy     <= 1'b0;
    end else begin
      busy <= (count != '0) || (state == SEND);
      case (state)
        IDLE: begin
          if (count != '0) begin
            state    <= SEND;
            tx_valid <= 1'b1;
            tx_data  <= 8'hA5;
            byte_idx <= 5'd0;
            csum     <= 8'hA5;
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            if (is_last) begin
              if (count_nxt != '0) begin
                tx_data  <= 8'hA5;
                byte_idx <= 5'd0;
                csum     <= 8'hA5;
              end else begin
                state    <= IDLE;
                tx_valid <= 1'b0;
              end
            end else begin
              byte_idx <= idx_nxt;
              tx_data  <= byte_nxt;
              csum     <= csum ^ byte_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
